// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data_mem between the core LSU (port C)
// and a second bus master (port D). Each access takes an issue cycle followed by a
// response cycle. The core stall is generated here.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ARB_MODE = 0   // 0: round-robin on tie, 1: core always wins
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // core port
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wd_i,
  output logic [DATA_W-1:0] core_rd_o,
  output logic              core_stall_o,
  // DMA port
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wd_i,
  output logic              dma_gnt_o,
  output logic              dma_rvalid_o,
  output logic [DATA_W-1:0] dma_rd_o,
  // memory port
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wd_o,
  input  logic [DATA_W-1:0] mem_rd_i,
  // statistics
  output logic [31:0]       stall_cnt_o
);

  typedef enum logic [1:0] {StIdle, StCResp, StDResp} state_e;

  localparam logic GntCore = 1'b0;
  localparam logic GntDma  = 1'b1;

  state_e      state_q, state_d;
  logic        last_gnt_q, last_gnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        core_win, dma_win;

  // Arbitration: only evaluated in the issue (idle) cycle.
  always_comb begin
    core_win = 1'b0;
    dma_win  = 1'b0;
    if (state_q == StIdle) begin
      if (core_req_i && dma_req_i) begin
        // On a tie the master that did not win last time goes next, unless core has priority.
        if ((ARB_MODE != 0) || (last_gnt_q == GntDma)) begin
          core_win = 1'b1;
        end else begin
          dma_win = 1'b1;
        end
      end else begin
        core_win = core_req_i;
        dma_win  = dma_req_i;
      end
    end
  end

  // Next-state logic: issue cycle always followed by one response cycle.
  always_comb begin
    state_d    = StIdle;
    last_gnt_d = last_gnt_q;
    if (core_win) begin
      state_d    = StCResp;
      last_gnt_d = GntCore;
    end else if (dma_win) begin
      state_d    = StDResp;
      last_gnt_d = GntDma;
    end
  end

  // Stall counter: counts every cycle the core is held off while requesting; wraps.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (core_req_i && core_stall_o) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // State registers; reset drops any in-flight response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      last_gnt_q  <= GntDma;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Memory-side outputs: winner's attributes pass straight through in the issue cycle.
  // Gated by rst_ni so nothing reaches the memory while reset is held.
  always_comb begin
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_wd_o   = '0;
    if (rst_ni) begin
      if (core_win) begin
        mem_req_o  = 1'b1;
        mem_we_o   = core_we_i;
        mem_addr_o = core_addr_i;
        mem_wd_o   = core_wd_i;
      end else if (dma_win) begin
        mem_req_o  = 1'b1;
        mem_we_o   = dma_we_i;
        mem_addr_o = dma_addr_i;
        mem_wd_o   = dma_wd_i;
      end
    end
  end

  // Master-side outputs: responses depend only on the registered state, never on mem_rd_i
  // for any request or stall signal.
  always_comb begin
    core_rd_o    = '0;
    dma_rd_o     = '0;
    dma_rvalid_o = 1'b0;
    dma_gnt_o    = rst_ni && dma_win;
    core_stall_o = !rst_ni || (core_req_i && (state_q != StCResp));
    if (rst_ni) begin
      if (state_q == StCResp) begin
        core_rd_o = mem_rd_i;
      end
      if (state_q == StDResp) begin
        dma_rvalid_o = 1'b1;
        dma_rd_o     = mem_rd_i;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: stimulus pushes expected issues/responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_ni;
  // DUT0 (round-robin)
  logic        core_req, core_we, core_stall;
  logic [31:0] core_addr, core_wd, core_rd;
  logic        dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [31:0] dma_addr, dma_wd, dma_rd;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd, stall_cnt;
  // DUT1 (fixed priority)
  logic        c1_req, c1_stall, d1_req, d1_gnt, d1_rvalid, m1_req, m1_we;
  logic [31:0] c1_rd, d1_rd, m1_addr, m1_wd, s1_cnt;

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_ni),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_wd_i(core_wd), .core_rd_o(core_rd), .core_stall_o(core_stall),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wd_i(dma_wd),
    .dma_gnt_o(dma_gnt), .dma_rvalid_o(dma_rvalid), .dma_rd_o(dma_rd),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wd_o(mem_wd),
    .mem_rd_i(mem_rd), .stall_cnt_o(stall_cnt)
  );

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_ni),
    .core_req_i(c1_req), .core_we_i(1'b0), .core_addr_i(32'h100),
    .core_wd_i(32'h0), .core_rd_o(c1_rd), .core_stall_o(c1_stall),
    .dma_req_i(d1_req), .dma_we_i(1'b0), .dma_addr_i(32'h200), .dma_wd_i(32'h0),
    .dma_gnt_o(d1_gnt), .dma_rvalid_o(d1_rvalid), .dma_rd_o(d1_rd),
    .mem_req_o(m1_req), .mem_we_o(m1_we), .mem_addr_o(m1_addr), .mem_wd_o(m1_wd),
    .mem_rd_i(32'h5A5A_5A5A), .stall_cnt_o(s1_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  // Synchronous-read memory model for DUT0.
  logic [31:0] mem [64];
  logic [31:0] rd_q = '0;
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[4] = 32'hDEAD_BEEF;
  end
  always @(posedge clk) begin
    if (mem_req) begin
      rd_q <= mem[mem_addr[7:2]];
      if (mem_we) mem[mem_addr[7:2]] = mem_wd;
    end
  end
  assign mem_rd = rd_q;

  // Scoreboard queues: issue = {dma, we, addr, wd}; dma response = {check, data}.
  logic [65:0] issue_q [$];
  logic [31:0] core_q  [$];
  logic [32:0] dma_q   [$];

  always @(negedge clk) begin
    logic [65:0] ei;
    logic [32:0] ed;
    if (rst_ni) begin
      if (mem_req) begin
        if (issue_q.size() == 0) fail_now("issue_unexpected");
        else begin
          ei = issue_q.pop_front();
          check("issue", {dma_gnt, mem_we, mem_addr, mem_wd}, ei);
        end
      end else if (dma_gnt) begin
        fail_now("gnt_without_req");
      end
      if (core_req && !core_stall) begin
        if (core_q.size() == 0) fail_now("core_done_unexpected");
        else check("core_rd", core_rd, core_q.pop_front());
      end
      if (dma_rvalid) begin
        if (dma_q.size() == 0) fail_now("dma_rvalid_unexpected");
        else begin
          ed = dma_q.pop_front();
          if (ed[32]) check("dma_rd", dma_rd, ed[31:0]);
        end
      end
    end
  end

  task automatic core_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             output int waits);
    core_req = 1'b1; core_we = we; core_addr = addr; core_wd = wd;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (core_stall && waits < 20);
    if (core_stall) fail_now("core_timeout");
    @(posedge clk); #1;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wd = '0;
  endtask

  task automatic dma_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            output int waits);
    dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wd = wd;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!dma_gnt && waits < 20);
    if (!dma_gnt) fail_now("dma_timeout");
    @(posedge clk); #1;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wd = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w1, w2, g1, g2;
    rst_ni = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40; core_wd = '0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h44; dma_wd = '0;
    c1_req = 1'b0; d1_req = 1'b0;

    // Test 1: reset with both requesting, then first tie goes to core.
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_dma_gnt", dma_gnt, 1'b0);
    check("rst_stall", core_stall, 1'b1);
    check("rst_mem_addr", {mem_we, mem_addr, mem_wd}, '0);
    check("rst_rvalid", dma_rvalid, 1'b0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_core_rd", core_rd, 32'd0);
    @(posedge clk); #1;
    issue_q.push_back({1'b0, 1'b0, 32'h40, 32'h0});
    issue_q.push_back({1'b1, 1'b0, 32'h44, 32'h0});
    core_q.push_back(32'h1000_0010);
    dma_q.push_back({1'b1, 32'h1000_0011});
    fork
      rst_ni = 1'b1;
      core_access(1'b0, 32'h40, 32'h0, w1);
      dma_access(1'b0, 32'h44, 32'h0, g1);
    join
    check("t1_core_waits", w1, 2);
    check("t1_dma_waits", g1, 3);
    repeat (2) @(posedge clk); #1;
    check("t1_stall_cnt", stall_cnt, 32'd1);

    // Test 2: uncontended core load, stalled exactly one cycle.
    issue_q.push_back({1'b0, 1'b0, 32'h10, 32'h0});
    core_q.push_back(32'hDEAD_BEEF);
    core_access(1'b0, 32'h10, 32'h0, w1);
    check("t2_core_waits", w1, 2);
    @(negedge clk);
    check("t2_stall_cnt", stall_cnt, 32'd2);
    @(posedge clk); #1;

    // Test 3: uncontended DMA write.
    issue_q.push_back({1'b1, 1'b1, 32'h20, 32'h1234});
    dma_q.push_back({1'b0, 32'h0});
    dma_access(1'b1, 32'h20, 32'h1234, g1);
    check("t3_gnt_waits", g1, 1);
    @(negedge clk);
    check("t3_rvalid", dma_rvalid, 1'b1);
    check("t3_resp_mem_req", mem_req, 1'b0);
    @(negedge clk);
    check("t3_after_mem_req", mem_req, 1'b0);
    check("t3_after_rvalid", dma_rvalid, 1'b0);
    @(posedge clk); #1;

    // Test 4: both masters back to back, round-robin C, D, C, D.
    issue_q.push_back({1'b0, 1'b0, 32'h24, 32'h0});
    issue_q.push_back({1'b1, 1'b1, 32'h28, 32'hBEEF_0028});
    issue_q.push_back({1'b0, 1'b0, 32'h28, 32'h0});
    issue_q.push_back({1'b1, 1'b0, 32'h20, 32'h0});
    core_q.push_back(32'h1000_0009);
    core_q.push_back(32'hBEEF_0028);
    dma_q.push_back({1'b0, 32'h0});
    dma_q.push_back({1'b1, 32'h1234});
    fork
      begin
        core_access(1'b0, 32'h24, 32'h0, w1);
        core_access(1'b0, 32'h28, 32'h0, w2);
      end
      begin
        dma_access(1'b1, 32'h28, 32'hBEEF_0028, g1);
        dma_access(1'b0, 32'h20, 32'h0, g2);
      end
    join
    check("t4_core1_waits", w1, 2);
    check("t4_core2_waits", w2, 4);
    check("t4_dma1_waits", g1, 3);
    check("t4_dma2_waits", g2, 4);
    repeat (2) @(posedge clk); #1;
    check("t4_stall_cnt", stall_cnt, 32'd6);

    // Test 6: reset pulse during the core response cycle.
    issue_q.push_back({1'b0, 1'b0, 32'h10, 32'h0});
    core_req = 1'b1; core_addr = 32'h10;
    @(negedge clk);
    check("t6_issue_stall", core_stall, 1'b1);
    @(posedge clk); #1;
    check("t6_resp_stall", core_stall, 1'b0);
    check("t6_stall_cnt_pre", stall_cnt, 32'd7);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_core_rd", core_rd, 32'd0);
    check("t6_rst_stall", core_stall, 1'b1);
    check("t6_rst_stall_cnt", stall_cnt, 32'd0);
    check("t6_rst_rvalid", dma_rvalid, 1'b0);
    core_req = 1'b0; core_addr = '0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("t6_post_rvalid", dma_rvalid, 1'b0);
      check("t6_post_mem_req", mem_req, 1'b0);
    end
    @(posedge clk); #1;

    // Test 5: fixed priority, core holds every issue slot while DMA waits.
    c1_req = 1'b1; d1_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t5_no_gnt", d1_gnt, 1'b0);
      check("t5_mem_req", m1_req, (i % 2) == 0);
      if ((i % 2) == 0) check("t5_issue", {m1_we, m1_addr, m1_wd}, {1'b0, 32'h100, 32'h0});
      else check("t5_core_resp", {c1_stall, c1_rd}, {1'b0, 32'h5A5A_5A5A});
    end
    @(posedge clk); #1;
    c1_req = 1'b0;
    @(negedge clk);
    check("t5_dma_gnt", d1_gnt, 1'b1);
    check("t5_dma_addr", m1_addr, 32'h200);
    @(posedge clk); #1;
    d1_req = 1'b0;
    @(negedge clk);
    check("t5_dma_resp", {d1_rvalid, d1_rd}, {1'b1, 32'h5A5A_5A5A});
    check("t5_stall_cnt", s1_cnt, 32'd4);

    check("issue_q_empty", issue_q.size(), 0);
    check("core_q_empty", core_q.size(), 0);
    check("dma_q_empty", dma_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
